// File: rtl/mul_ctrl_hilo.sv
// Sequencer and HI/LO register file for the shift-add unsigned multiplier.
// Runs LOAD -> N_ITER x MULTU -> OUT -> capture, and serves MFHI/MFLO reads.
module mul_ctrl_hilo #(
    parameter int         N_ITER  = 32,
    parameter logic [5:0] F_MULTU = 6'b011001,
    parameter logic [5:0] F_MFHI  = 6'b010000,
    parameter logic [5:0] F_MFLO  = 6'b010010,
    parameter logic [5:0] C_LOAD  = 6'b000000,
    parameter logic [5:0] C_OUT   = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [5:0]  mul_signal,
    output logic [31:0] mul_dataA,
    output logic [31:0] mul_dataB,
    input  logic [63:0] mul_dataOut,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_OUTP,
        S_CAPT
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(N_ITER - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  sig_q, sig_d;
    logic [31:0] data_a_q, data_a_d;
    logic [31:0] data_b_q, data_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rd_q, rd_d;
    logic        done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rd_d     = rd_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (funct == F_MULTU) begin
                        data_a_d = srcA;
                        data_b_d = srcB;
                        state_d  = S_LOAD;
                    end else if (funct == F_MFHI) begin
                        rd_d   = hi_q;
                        done_d = 1'b1;
                    end else if (funct == F_MFLO) begin
                        rd_d   = lo_q;
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                cnt_d   = 6'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_OUTP;
                end
            end
            S_OUTP: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                hi_d    = mul_dataOut[63:32];
                lo_d    = mul_dataOut[31:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The multiplier code follows the state being entered so it is aligned with it.
        case (state_d)
            S_RUN:          sig_d = F_MULTU;
            S_OUTP, S_CAPT: sig_d = C_OUT;
            default:        sig_d = C_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            sig_q    <= C_LOAD;
            data_a_q <= 32'd0;
            data_b_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            rd_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sig_q    <= sig_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            rd_q     <= rd_d;
            done_q   <= done_d;
        end
    end

    assign mul_signal = sig_q;
    assign mul_dataA  = data_a_q;
    assign mul_dataB  = data_b_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign rd_data    = rd_q;

endmodule

// File: tb/tb_mul_ctrl_hilo.sv
// Directed bench for mul_ctrl_hilo with a behavioural shift-add multiplier
// attached to the Signal/data interface.
module tb_mul_ctrl_hilo;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] C_LOAD  = 6'b000000;
    localparam logic [5:0] C_OUT   = 6'b111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] srcA, srcB;
    logic [5:0]  mul_signal;
    logic [31:0] mul_dataA, mul_dataB;
    logic [63:0] mul_dataOut = 64'd0;
    logic        busy, done;
    logic [31:0] hi, lo, rd_data;

    int total = 0;
    int bad   = 0;

    mul_ctrl_hilo dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .funct      (funct),
        .srcA       (srcA),
        .srcB       (srcB),
        .mul_signal (mul_signal),
        .mul_dataA  (mul_dataA),
        .mul_dataB  (mul_dataB),
        .mul_dataOut(mul_dataOut),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Shift-add multiplier: load {0,B}, add A into the upper half when bit 0 is set, shift right.
    logic [31:0] m_a;
    logic [63:0] m_prod = 64'd0;
    logic [32:0] m_sum;
    always @(posedge clk) begin
        m_sum = {1'b0, m_prod[63:32]} + (m_prod[0] ? {1'b0, m_a} : 33'd0);
        case (mul_signal)
            C_LOAD: begin
                m_a    <= mul_dataA;
                m_prod <= {32'd0, mul_dataB};
            end
            F_MULTU: m_prod <= {m_sum, m_prod[31:1]};
            C_OUT:   mul_dataOut <= m_prod;
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic multu(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        int n, nl, nm, no;
        n = 0; nl = 0; nm = 0; no = 0;
        start = 1'b1; funct = F_MULTU; srcA = a; srcB = b;
        tick();
        start = 1'b0; funct = 6'd0;
        while (!done && n < 100) begin
            if (mul_signal == C_LOAD) nl++;
            else if (mul_signal == F_MULTU) nm++;
            else if (mul_signal == C_OUT) no++;
            tick();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd35);
        chk({tag, " load cycles"}, 64'(nl), 64'd1);
        chk({tag, " multu cycles"}, 64'(nm), 64'd32);
        chk({tag, " out cycles"}, 64'(no), 64'd2);
        chk({tag, " busy in done cycle"}, 64'(busy), 64'd0);
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
        tick();
        chk({tag, " done single pulse"}, 64'(done), 64'd0);
    endtask

    task automatic mfread(input string tag, input logic [5:0] f, input logic [31:0] exp);
        start = 1'b1; funct = f;
        tick();
        start = 1'b0; funct = 6'd0;
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " rd_data"}, 64'(rd_data), 64'(exp));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        tick();
        chk({tag, " done drop"}, 64'(done), 64'd0);
        chk({tag, " rd_data held"}, 64'(rd_data), 64'(exp));
    endtask

    initial begin
        int ndone, n;
        reset = 1'b1; start = 1'b0; funct = 6'd0; srcA = 32'd0; srcB = 32'd0;
        tick();
        tick();
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst signal", 64'(mul_signal), 64'(C_LOAD));
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        chk("rst rd_data", 64'(rd_data), 64'd0);
        chk("rst dataA", 64'(mul_dataA), 64'd0);
        reset = 1'b0;
        tick();

        multu("m3x5", 32'd3, 32'd5, 32'h0, 32'h0000000F);
        multu("mffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        mfread("mfhi", F_MFHI, 32'hFFFFFFFE);
        mfread("mflo", F_MFLO, 32'h00000001);

        // Unrecognised funct in IDLE does nothing.
        start = 1'b1; funct = 6'b100000; srcA = 32'hDEAD; srcB = 32'hBEEF;
        tick();
        start = 1'b0; funct = 6'd0;
        chk("bad funct busy", 64'(busy), 64'd0);
        chk("bad funct done", 64'(done), 64'd0);
        chk("bad funct signal", 64'(mul_signal), 64'(C_LOAD));
        chk("bad funct hi", 64'(hi), 64'hFFFFFFFE);
        chk("bad funct lo", 64'(lo), 64'h1);
        chk("bad funct rd_data", 64'(rd_data), 64'h1);
        chk("bad funct dataA", 64'(mul_dataA), 64'hFFFFFFFF);
        tick();

        multu("m_x0", 32'h12345678, 32'd0, 32'h0, 32'h0);
        multu("m10000sq", 32'h00010000, 32'h00010000, 32'h00000001, 32'h0);

        // Start while busy must be ignored.
        start = 1'b1; funct = F_MULTU; srcA = 32'd2; srcB = 32'd2;
        tick();
        start = 1'b0;
        repeat (10) tick();
        start = 1'b1; funct = F_MULTU; srcA = 32'd7; srcB = 32'd9;
        tick();
        start = 1'b0; funct = 6'd0;
        chk("busy ign dataA", 64'(mul_dataA), 64'd2);
        chk("busy ign dataB", 64'(mul_dataB), 64'd2);
        ndone = 0;
        for (int i = 0; i < 45; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("busy ign done count", 64'(ndone), 64'd1);
        chk("busy ign hi", 64'(hi), 64'd0);
        chk("busy ign lo", 64'(lo), 64'd4);
        chk("busy ign idle", 64'(busy), 64'd0);

        // Reset in the middle of RUN aborts cleanly.
        start = 1'b1; funct = F_MULTU; srcA = 32'd5; srcB = 32'd5;
        tick();
        start = 1'b0; funct = 6'd0;
        repeat (13) tick();
        chk("mid run busy", 64'(busy), 64'd1);
        chk("mid run signal", 64'(mul_signal), 64'(F_MULTU));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort signal", 64'(mul_signal), 64'(C_LOAD));
        chk("abort done", 64'(done), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("abort no late done", 64'(ndone), 64'd0);

        multu("m6x7", 32'd6, 32'd7, 32'h0, 32'd42);

        // A request issued in the done cycle is accepted.
        start = 1'b1; funct = F_MULTU; srcA = 32'd3; srcB = 32'd3;
        tick();
        start = 1'b0; funct = 6'd0;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("b2b first done", 64'(done), 64'd1);
        start = 1'b1; funct = F_MFLO;
        tick();
        start = 1'b0; funct = 6'd0;
        chk("b2b mflo done", 64'(done), 64'd1);
        chk("b2b mflo rd_data", 64'(rd_data), 64'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
